// File: rtl/tl_ul_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tl_ul_arb_pkg
//  Description : Shared TL-UL field widths, opcode constants and the A-beat
//                payload struct for the 2:1 TL-UL arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package tl_ul_arb_pkg;

    localparam int c_opcode_w = 3;
    localparam int c_param_w  = 3;
    localparam int c_size_w   = 2;
    localparam int c_csrc_w   = 2;    // client-side source width
    localparam int c_msrc_w   = 3;    // manager-side source width (client id + source)
    localparam int c_mask_w   = 4;
    localparam int c_data_w   = 32;
    localparam int c_cnt_w    = 3;    // outstanding counters hold 0..7

    localparam logic [c_opcode_w-1:0] c_op_get             = 3'd4;
    localparam logic [c_opcode_w-1:0] c_op_put_full        = 3'd0;
    localparam logic [c_opcode_w-1:0] c_op_put_partial     = 3'd1;
    localparam logic [c_opcode_w-1:0] c_op_access_ack      = 3'd0;
    localparam logic [c_opcode_w-1:0] c_op_access_ack_data = 3'd1;

    // Address is carried beside the struct because its width is a module parameter.
    typedef struct packed {
        logic [c_opcode_w-1:0] opcode;
        logic [c_param_w-1:0]  param;
        logic [c_size_w-1:0]   size;
        logic [c_msrc_w-1:0]   source;
        logic [c_mask_w-1:0]   mask;
        logic [c_data_w-1:0]   data;
    } a_beat_t;

endpackage
`default_nettype wire

// File: rtl/tl_ul_a_slice.sv
`default_nettype none
// ============================================================================
//  Module      : tl_ul_a_slice
//  Description : One-entry valid/ready register slice for TL-UL A beats.
//                Loads when empty or when the downstream accepts in the same
//                cycle, giving full throughput with one cycle of latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module tl_ul_a_slice
    import tl_ul_arb_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  a_beat_t           i_beat,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              o_valid,
    input  logic              i_ready,
    output a_beat_t           o_beat,
    output logic [ADDR_W-1:0] o_addr
);

    logic              r_valid;
    a_beat_t           r_beat;
    logic [ADDR_W-1:0] r_addr;

    assign o_ready = ~r_valid | i_ready;
    assign o_valid = r_valid;
    assign o_beat  = r_beat;
    assign o_addr  = r_addr;

    // Occupancy: refill or drain whenever the entry is free to change.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
        end else if (o_ready) begin
            r_valid <= i_valid;
        end
    end

    // Payload only moves on a load, so it stays stable while stalled.
    always_ff @(posedge clk) begin
        if (o_ready && i_valid) begin
            r_beat <= i_beat;
            r_addr <= i_addr;
        end
    end

endmodule
`default_nettype wire

// File: rtl/tl_ul_arbiter_2to1.sv
`default_nettype none
// ============================================================================
//  Module      : tl_ul_arbiter_2to1
//  Description : Round-robin 2:1 TL-UL arbiter. Client A beats are tagged with
//                the client id in the top source bit and registered; D beats
//                are routed back combinationally on that bit. Per-client
//                outstanding counters throttle issue and flag stray responses.
//  Revision    : 1.0 - initial release
// ============================================================================
module tl_ul_arbiter_2to1
    import tl_ul_arb_pkg::*;
#(
    parameter int MAX_OUTST = 4,
    parameter int ADDR_W    = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    // client 0 A
    input  logic                  c0_a_valid,
    output logic                  c0_a_ready,
    input  logic [c_opcode_w-1:0] c0_a_opcode,
    input  logic [c_param_w-1:0]  c0_a_param,
    input  logic [c_size_w-1:0]   c0_a_size,
    input  logic [c_csrc_w-1:0]   c0_a_source,
    input  logic [ADDR_W-1:0]     c0_a_address,
    input  logic [c_mask_w-1:0]   c0_a_mask,
    input  logic [c_data_w-1:0]   c0_a_data,
    // client 1 A
    input  logic                  c1_a_valid,
    output logic                  c1_a_ready,
    input  logic [c_opcode_w-1:0] c1_a_opcode,
    input  logic [c_param_w-1:0]  c1_a_param,
    input  logic [c_size_w-1:0]   c1_a_size,
    input  logic [c_csrc_w-1:0]   c1_a_source,
    input  logic [ADDR_W-1:0]     c1_a_address,
    input  logic [c_mask_w-1:0]   c1_a_mask,
    input  logic [c_data_w-1:0]   c1_a_data,
    // client 0 D
    output logic                  c0_d_valid,
    input  logic                  c0_d_ready,
    output logic [c_opcode_w-1:0] c0_d_opcode,
    output logic [c_size_w-1:0]   c0_d_size,
    output logic [c_csrc_w-1:0]   c0_d_source,
    output logic                  c0_d_denied,
    output logic [c_data_w-1:0]   c0_d_data,
    // client 1 D
    output logic                  c1_d_valid,
    input  logic                  c1_d_ready,
    output logic [c_opcode_w-1:0] c1_d_opcode,
    output logic [c_size_w-1:0]   c1_d_size,
    output logic [c_csrc_w-1:0]   c1_d_source,
    output logic                  c1_d_denied,
    output logic [c_data_w-1:0]   c1_d_data,
    // manager A
    output logic                  m_a_valid,
    input  logic                  m_a_ready,
    output logic [c_opcode_w-1:0] m_a_opcode,
    output logic [c_param_w-1:0]  m_a_param,
    output logic [c_size_w-1:0]   m_a_size,
    output logic [c_msrc_w-1:0]   m_a_source,
    output logic [ADDR_W-1:0]     m_a_address,
    output logic [c_mask_w-1:0]   m_a_mask,
    output logic [c_data_w-1:0]   m_a_data,
    // manager D
    input  logic                  m_d_valid,
    output logic                  m_d_ready,
    input  logic [c_opcode_w-1:0] m_d_opcode,
    input  logic [c_size_w-1:0]   m_d_size,
    input  logic [c_msrc_w-1:0]   m_d_source,
    input  logic                  m_d_denied,
    input  logic [c_data_w-1:0]   m_d_data,
    output logic                  err
);

    localparam logic [c_cnt_w-1:0] c_max_outst = c_cnt_w'(MAX_OUTST);

    logic [1:0]        w_a_valid;
    logic [1:0]        w_d_ready;
    logic [1:0]        w_elig;
    logic [1:0]        w_grant;
    logic [1:0]        w_a_fire;
    logic [1:0]        w_d_hit;
    logic [1:0]        w_d_fire;
    logic [1:0]        w_d_err;
    logic              w_slice_ready;
    logic              w_load_ok;
    a_beat_t           w_beat;
    logic [ADDR_W-1:0] w_addr;
    a_beat_t           w_out_beat;
    logic              r_rr;
    logic              r_err;

    assign w_a_valid = {c1_a_valid, c0_a_valid};
    assign w_d_ready = {c1_d_ready, c0_d_ready};

    generate
        for (genvar n = 0; n < 2; n++) begin : g_client
            localparam logic c_id = 1'(n);
            logic [c_cnt_w-1:0] r_outst;

            assign w_elig[n]   = w_a_valid[n] & (r_outst < c_max_outst);
            assign w_d_hit[n]  = m_d_valid & (m_d_source[c_msrc_w-1] == c_id);
            assign w_d_fire[n] = w_d_hit[n] & w_d_ready[n];
            assign w_d_err[n]  = w_d_fire[n] & (r_outst == '0);

            // Outstanding count: A fire adds, D fire removes, both together cancel; never below 0.
            always_ff @(posedge clock) begin
                if (reset) begin
                    r_outst <= '0;
                end else if (w_a_fire[n] && !w_d_fire[n]) begin
                    r_outst <= r_outst + 1'b1;
                end else if (w_d_fire[n] && !w_a_fire[n] && (r_outst != '0)) begin
                    r_outst <= r_outst - 1'b1;
                end
            end
        end
    endgenerate

    // rr names the preferred client; a lone eligible client wins regardless.
    assign w_grant[0] = w_elig[0] & (~w_elig[1] | ~r_rr);
    assign w_grant[1] = w_elig[1] & (~w_elig[0] |  r_rr);

    assign w_load_ok  = w_slice_ready & ~reset;
    assign w_a_fire   = w_grant & {2{w_load_ok}};
    assign c0_a_ready = w_a_fire[0];
    assign c1_a_ready = w_a_fire[1];

    // Select the granted client's beat and tag its id into the top source bit.
    always_comb begin
        if (w_grant[1]) begin
            w_beat = '{opcode: c1_a_opcode, param: c1_a_param, size: c1_a_size,
                       source: {1'b1, c1_a_source}, mask: c1_a_mask, data: c1_a_data};
            w_addr = c1_a_address;
        end else begin
            w_beat = '{opcode: c0_a_opcode, param: c0_a_param, size: c0_a_size,
                       source: {1'b0, c0_a_source}, mask: c0_a_mask, data: c0_a_data};
            w_addr = c0_a_address;
        end
    end

    tl_ul_a_slice #(
        .ADDR_W (ADDR_W)
    ) u_slice (
        .clk     (clock),
        .rst     (reset),
        .i_valid (|w_a_fire),
        .o_ready (w_slice_ready),
        .i_beat  (w_beat),
        .i_addr  (w_addr),
        .o_valid (m_a_valid),
        .i_ready (m_a_ready),
        .o_beat  (w_out_beat),
        .o_addr  (m_a_address)
    );

    assign m_a_opcode = w_out_beat.opcode;
    assign m_a_param  = w_out_beat.param;
    assign m_a_size   = w_out_beat.size;
    assign m_a_source = w_out_beat.source;
    assign m_a_mask   = w_out_beat.mask;
    assign m_a_data   = w_out_beat.data;

    // Round-robin pointer moves to the other client after every grant.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rr <= 1'b0;
        end else if (w_a_fire[0]) begin
            r_rr <= 1'b1;
        end else if (w_a_fire[1]) begin
            r_rr <= 1'b0;
        end
    end

    // Sticky flag for a response arriving at a client with nothing outstanding.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (|w_d_err) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;

    // D routing: steer by client id, broadcast the remaining fields.
    assign c0_d_valid  = w_d_hit[0];
    assign c1_d_valid  = w_d_hit[1];
    assign m_d_ready   = m_d_source[c_msrc_w-1] ? c1_d_ready : c0_d_ready;
    assign c0_d_opcode = m_d_opcode;
    assign c1_d_opcode = m_d_opcode;
    assign c0_d_size   = m_d_size;
    assign c1_d_size   = m_d_size;
    assign c0_d_source = m_d_source[c_csrc_w-1:0];
    assign c1_d_source = m_d_source[c_csrc_w-1:0];
    assign c0_d_denied = m_d_denied;
    assign c1_d_denied = m_d_denied;
    assign c0_d_data   = m_d_data;
    assign c1_d_data   = m_d_data;

endmodule
`default_nettype wire

// File: tb/tb_tl_ul_arbiter_2to1.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tl_ul_arbiter_2to1
//  Description : Self-checking bench for tl_ul_arbiter_2to1. Directed cases
//                plus randomized traffic, checked by a scoreboard monitor that
//                models arbitration, outstanding limits and D routing.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tl_ul_arbiter_2to1;

    localparam int MAX_OUTST = 4;
    localparam int ADDR_W    = 32;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        c0_a_valid = 0, c1_a_valid = 0;
    logic        c0_a_ready, c1_a_ready;
    logic [2:0]  c0_a_opcode = 0, c1_a_opcode = 0, c0_a_param = 0, c1_a_param = 0;
    logic [1:0]  c0_a_size = 0, c1_a_size = 0, c0_a_source = 0, c1_a_source = 0;
    logic [31:0] c0_a_address = 0, c1_a_address = 0, c0_a_data = 0, c1_a_data = 0;
    logic [3:0]  c0_a_mask = 0, c1_a_mask = 0;
    logic        c0_d_valid, c1_d_valid;
    logic        c0_d_ready = 1, c1_d_ready = 1;
    logic [2:0]  c0_d_opcode, c1_d_opcode;
    logic [1:0]  c0_d_size, c1_d_size, c0_d_source, c1_d_source;
    logic        c0_d_denied, c1_d_denied;
    logic [31:0] c0_d_data, c1_d_data;
    logic        m_a_valid;
    logic        m_a_ready = 1;
    logic [2:0]  m_a_opcode, m_a_param, m_a_source;
    logic [1:0]  m_a_size;
    logic [31:0] m_a_address, m_a_data;
    logic [3:0]  m_a_mask;
    logic        m_d_valid = 0;
    logic        m_d_ready;
    logic [2:0]  m_d_opcode = 0, m_d_source = 0;
    logic [1:0]  m_d_size = 0;
    logic        m_d_denied = 0;
    logic [31:0] m_d_data = 0;
    logic        err;

    always #5 clock = ~clock;

    tl_ul_arbiter_2to1 #(.MAX_OUTST(MAX_OUTST), .ADDR_W(ADDR_W)) dut (
        .clock(clock), .reset(reset),
        .c0_a_valid(c0_a_valid), .c0_a_ready(c0_a_ready), .c0_a_opcode(c0_a_opcode),
        .c0_a_param(c0_a_param), .c0_a_size(c0_a_size), .c0_a_source(c0_a_source),
        .c0_a_address(c0_a_address), .c0_a_mask(c0_a_mask), .c0_a_data(c0_a_data),
        .c1_a_valid(c1_a_valid), .c1_a_ready(c1_a_ready), .c1_a_opcode(c1_a_opcode),
        .c1_a_param(c1_a_param), .c1_a_size(c1_a_size), .c1_a_source(c1_a_source),
        .c1_a_address(c1_a_address), .c1_a_mask(c1_a_mask), .c1_a_data(c1_a_data),
        .c0_d_valid(c0_d_valid), .c0_d_ready(c0_d_ready), .c0_d_opcode(c0_d_opcode),
        .c0_d_size(c0_d_size), .c0_d_source(c0_d_source), .c0_d_denied(c0_d_denied),
        .c0_d_data(c0_d_data),
        .c1_d_valid(c1_d_valid), .c1_d_ready(c1_d_ready), .c1_d_opcode(c1_d_opcode),
        .c1_d_size(c1_d_size), .c1_d_source(c1_d_source), .c1_d_denied(c1_d_denied),
        .c1_d_data(c1_d_data),
        .m_a_valid(m_a_valid), .m_a_ready(m_a_ready), .m_a_opcode(m_a_opcode),
        .m_a_param(m_a_param), .m_a_size(m_a_size), .m_a_source(m_a_source),
        .m_a_address(m_a_address), .m_a_mask(m_a_mask), .m_a_data(m_a_data),
        .m_d_valid(m_d_valid), .m_d_ready(m_d_ready), .m_d_opcode(m_d_opcode),
        .m_d_size(m_d_size), .m_d_source(m_d_source), .m_d_denied(m_d_denied),
        .m_d_data(m_d_data),
        .err(err)
    );

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [78:0] sbq[$];
    int          m_outst [2] = '{0, 0};
    bit          m_rr  = 1'b0;
    bit          m_err = 1'b0;

    task automatic check(input string name, input logic [78:0] act, input logic [78:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [78:0] pack(input logic [2:0] src, input logic [2:0] op,
                                         input logic [2:0] prm, input logic [1:0] sz,
                                         input logic [31:0] addr, input logic [3:0] msk,
                                         input logic [31:0] dat);
        return {src, op, prm, sz, addr, msk, dat};
    endfunction

    // Scoreboard monitor: samples mid-cycle, predicts from the model, then advances it.
    always @(negedge clock) begin
        bit       loadable;
        bit [1:0] valid, elig, exp_rdy, d_fire;
        bit       sel;

        // Manager A side: one buffered beat at most, in client-fire order.
        check("m_a_valid", m_a_valid, sbq.size() != 0);
        if (m_a_valid && sbq.size() != 0)
            check("m_a_beat", pack(m_a_source, m_a_opcode, m_a_param, m_a_size,
                                   m_a_address, m_a_mask, m_a_data), sbq[0]);
        loadable = (sbq.size() == 0) || m_a_ready;
        if (m_a_valid && m_a_ready && sbq.size() != 0) void'(sbq.pop_front());

        // Arbitration
        valid   = {c1_a_valid, c0_a_valid};
        elig[0] = valid[0] && (m_outst[0] < MAX_OUTST);
        elig[1] = valid[1] && (m_outst[1] < MAX_OUTST);
        exp_rdy = 2'b00;
        if (!reset && loadable) begin
            if (elig == 2'b11) exp_rdy[m_rr] = 1'b1;
            else               exp_rdy = elig;
        end
        check("c0_a_ready", c0_a_ready, exp_rdy[0]);
        check("c1_a_ready", c1_a_ready, exp_rdy[1]);
        if (exp_rdy[0]) begin
            sbq.push_back(pack({1'b0, c0_a_source}, c0_a_opcode, c0_a_param, c0_a_size,
                               c0_a_address, c0_a_mask, c0_a_data));
            m_rr = 1'b1;
        end
        if (exp_rdy[1]) begin
            sbq.push_back(pack({1'b1, c1_a_source}, c1_a_opcode, c1_a_param, c1_a_size,
                               c1_a_address, c1_a_mask, c1_a_data));
            m_rr = 1'b0;
        end

        // D routing
        check("err", err, m_err);
        sel = m_d_source[2];
        check("c0_d_valid", c0_d_valid, m_d_valid && !sel);
        check("c1_d_valid", c1_d_valid, m_d_valid && sel);
        check("m_d_ready", m_d_ready, sel ? c1_d_ready : c0_d_ready);
        check("c0_d_fields", {c0_d_opcode, c0_d_size, c0_d_source, c0_d_denied, c0_d_data},
              {m_d_opcode, m_d_size, m_d_source[1:0], m_d_denied, m_d_data});
        check("c1_d_fields", {c1_d_opcode, c1_d_size, c1_d_source, c1_d_denied, c1_d_data},
              {m_d_opcode, m_d_size, m_d_source[1:0], m_d_denied, m_d_data});
        d_fire[0] = m_d_valid && !sel && c0_d_ready;
        d_fire[1] = m_d_valid && sel && c1_d_ready;

        if (reset) begin
            m_outst = '{0, 0};
            m_rr    = 1'b0;
            m_err   = 1'b0;
            sbq.delete();
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (d_fire[n] && m_outst[n] == 0) m_err = 1'b1;
                if (exp_rdy[n] && !d_fire[n]) m_outst[n]++;
                else if (d_fire[n] && !exp_rdy[n] && m_outst[n] > 0) m_outst[n]--;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        c0_a_valid = 0; c1_a_valid = 0; m_a_ready = 1;
        m_d_valid = 0; c0_d_ready = 1; c1_d_ready = 1;
    endtask

    task automatic do_reset();
        reset = 1; idle();
        tick(); tick();
        reset = 0;
    endtask

    task automatic rand_fields();
        c0_a_opcode = 3'($urandom); c0_a_param = 3'($urandom); c0_a_size = 2'($urandom);
        c0_a_source = 2'($urandom); c0_a_address = $urandom; c0_a_mask = 4'($urandom);
        c0_a_data = $urandom;
        c1_a_opcode = 3'($urandom); c1_a_param = 3'($urandom); c1_a_size = 2'($urandom);
        c1_a_source = 2'($urandom); c1_a_address = $urandom; c1_a_mask = 4'($urandom);
        c1_a_data = $urandom;
        m_d_opcode = 3'($urandom); m_d_size = 2'($urandom); m_d_denied = 1'($urandom);
        m_d_data = $urandom;
    endtask

    initial begin
        int fired;
        int n;

        repeat (3) tick();
        reset = 0;

        // Both clients always valid: grants alternate starting at client 0.
        rand_fields();
        c0_a_valid = 1; c1_a_valid = 1; m_a_ready = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            check("alt_grant", {c1_a_ready, c0_a_ready}, (i % 2) ? 2'b10 : 2'b01);
            if (i > 0) check("alt_src", {m_a_valid, m_a_source[2]}, {1'b1, 1'((i - 1) % 2)});
            tick();
            rand_fields();
        end

        // Stalled manager holds the beat steady.
        do_reset();
        c0_a_valid = 1; c0_a_opcode = 3'd4; c0_a_source = 2'd2; c0_a_address = 32'h1000;
        m_a_ready = 0;
        tick();
        c0_a_valid = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("stall_hold", {m_a_valid, m_a_source, m_a_address}, {1'b1, 3'b010, 32'h1000});
            tick();
        end
        m_a_ready = 1;
        tick(); tick();

        // Client 1 reaches the outstanding limit, then one response unblocks it.
        do_reset();
        c1_a_valid = 1; c1_a_opcode = 3'd4; m_a_ready = 1;
        fired = 0;
        for (int cyc = 0; cyc < 20 && fired < 4; cyc++) begin
            @(negedge clock);
            if (c1_a_ready) fired++;
            tick();
        end
        check("c1_issue_count", fired, 4);
        @(negedge clock);
        check("c1_blocked", c1_a_ready, 1'b0);
        tick();
        m_d_valid = 1; m_d_source = 3'b101; c1_d_ready = 1;
        @(negedge clock);
        check("c1_d_route", {c1_d_valid, c1_d_source, c1_a_ready}, {1'b1, 2'd1, 1'b0});
        tick();
        m_d_valid = 0;
        @(negedge clock);
        check("c1_unblocked", c1_a_ready, 1'b1);
        tick();
        c1_a_valid = 0;

        // Same-cycle A and D fire on client 0 leaves its count unchanged.
        do_reset();
        c0_a_valid = 1;
        tick(); tick();
        m_d_valid = 1; m_d_source = 3'b000; c0_d_ready = 1;
        tick();
        m_d_valid = 0;
        tick();
        @(negedge clock);
        check("c0_at_three", c0_a_ready, 1'b1);
        tick();
        @(negedge clock);
        check("c0_at_limit", c0_a_ready, 1'b0);
        tick();
        c0_a_valid = 0;

        // Response with nothing outstanding sets the sticky error.
        do_reset();
        m_d_valid = 1; m_d_source = 3'b000; c0_d_ready = 1;
        tick();
        m_d_valid = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("err_sticky", err, 1'b1);
            tick();
        end
        do_reset();
        @(negedge clock);
        check("err_cleared", err, 1'b0);
        tick();

        // Reset while the slice holds a beat drops it and restores client-0 priority.
        c0_a_valid = 1; m_a_ready = 0;
        tick();
        c0_a_valid = 0; c1_a_valid = 1;
        @(negedge clock);
        check("slice_full", m_a_valid, 1'b1);
        tick();
        reset = 1;
        tick();
        reset = 0; c0_a_valid = 1; c1_a_valid = 1; m_a_ready = 1;
        @(negedge clock);
        check("reset_drop", {m_a_valid, c1_a_ready, c0_a_ready}, 3'b001);
        tick();
        idle();
        tick();

        // Randomized traffic checked entirely by the monitor.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            reset      = ($urandom_range(0, 299) == 0);
            c0_a_valid = ($urandom_range(0, 3) != 0);
            c1_a_valid = ($urandom_range(0, 3) != 0);
            m_a_ready  = ($urandom_range(0, 3) != 0);
            c0_d_ready = ($urandom_range(0, 3) != 0);
            c1_d_ready = ($urandom_range(0, 3) != 0);
            rand_fields();
            m_d_valid  = 0;
            m_d_source = 3'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                n = $urandom_range(0, 1);
                if (m_outst[n] > 0 || $urandom_range(0, 63) == 0) begin
                    m_d_valid  = 1;
                    m_d_source = {1'(n), 2'($urandom)};
                end
            end
            tick();
        end

        reset = 0;
        idle();
        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
